// File: rtl/pe_sys_ctrl.sv
// Tile sequencer for the 4-row PE systolic array: command accept, skewed row feed, drain, store window.
// Optional performance counters are built only when PE_SYS_CTRL_PERF_CNT_EN is defined.
module pe_sys_ctrl #(
    parameter int COLS     = 16,
    parameter int K_WIDTH  = 12,
    parameter int PIPE_LAT = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_mode,
    input  logic [K_WIDTH-1:0] i_cmd_k_len,
    input  logic               i_cmd_y_sel,
    input  logic               i_data_avail,
    input  logic               i_abort,
    output logic [3:0]         o_feed_en,
    output logic [1:0]         o_mode_sel_out,
    output logic               o_psu_clr_out,
    output logic               o_y_sel_out,
    output logic               o_sys_buf_en_out,
    output logic               o_done,
    output logic               o_cmd_err,
    output logic [31:0]        o_busy_cycles,
    output logic [31:0]        o_stall_cycles
);

    localparam int DRAIN_LEN = 3 + PIPE_LAT;
    localparam int TMR_MAX   = (COLS > DRAIN_LEN) ? COLS : DRAIN_LEN;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'(DRAIN_LEN - 1);
    localparam logic [TMR_W-1:0] OUT_LD   = TMR_W'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [K_WIDTH-1:0] r_step;
    logic [K_WIDTH-1:0] w_step_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [1:0]         r_mode;
    logic               r_y_sel;
    logic               r_err_pend;
    logic               w_accept;
    logic               w_legal;
    logic               w_feed0;

    assign w_accept = i_cmd_valid & o_cmd_ready & ~i_abort;
    assign w_legal  = (i_cmd_mode != 2'b01);
    assign w_feed0  = (r_state == S_FEED) & i_data_avail & ~i_abort;

    always_comb begin
        w_next     = r_state;
        w_step_nxt = r_step;
        w_tmr_nxt  = r_tmr;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal) begin
                    w_step_nxt = i_cmd_k_len;
                    w_next     = (i_cmd_k_len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: w_next = S_FEED;
            S_FEED: begin
                if (i_data_avail) begin
                    w_step_nxt = r_step - K_WIDTH'(1);
                    if (r_step == K_WIDTH'(1)) begin
                        w_next    = S_DRAIN;
                        w_tmr_nxt = DRAIN_LD;
                    end
                end
            end
            S_DRAIN: begin
                if (r_tmr == '0) begin
                    w_next    = S_OUT;
                    w_tmr_nxt = OUT_LD;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            S_OUT: begin
                if (r_tmr == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort) begin
            w_next = S_IDLE;
        end
    end

    // Outputs are registered from the current state, so they trail the state register by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_step           <= '0;
            r_tmr            <= '0;
            r_mode           <= 2'b00;
            r_y_sel          <= 1'b0;
            r_err_pend       <= 1'b0;
            o_cmd_ready      <= 1'b0;
            o_feed_en        <= 4'b0000;
            o_mode_sel_out   <= 2'b00;
            o_psu_clr_out    <= 1'b0;
            o_y_sel_out      <= 1'b0;
            o_sys_buf_en_out <= 1'b0;
            o_done           <= 1'b0;
            o_cmd_err        <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_step     <= w_step_nxt;
            r_tmr      <= w_tmr_nxt;
            r_err_pend <= w_accept & ~w_legal;
            if (w_accept && w_legal) begin
                r_mode  <= i_cmd_mode;
                r_y_sel <= i_cmd_y_sel;
            end
            o_cmd_ready      <= (r_state == S_IDLE) && (w_next == S_IDLE);
            o_feed_en        <= i_abort ? 4'b0000 : {o_feed_en[2:0], w_feed0};
            o_psu_clr_out    <= (r_state == S_CLEAR) & ~i_abort;
            o_sys_buf_en_out <= (r_state == S_OUT) & ~i_abort;
            o_done           <= (r_state == S_DONE) & ~i_abort;
            o_cmd_err        <= r_err_pend & ~i_abort;
            if ((r_state == S_CLEAR) && !i_abort) begin
                o_mode_sel_out <= r_mode;
                o_y_sel_out    <= r_y_sel;
            end
        end
    end

`ifdef PE_SYS_CTRL_PERF_CNT_EN
    logic [31:0] r_busy;
    logic [31:0] r_stall;

    // Saturating; only reset clears them so totals survive aborted tiles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_busy != '1)) begin
                r_busy <= r_busy + 32'd1;
            end
            if ((r_state == S_FEED) && !i_data_avail && (r_stall != '1)) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign o_busy_cycles  = r_busy;
    assign o_stall_cycles = r_stall;
`else
    assign o_busy_cycles  = 32'd0;
    assign o_stall_cycles = 32'd0;
`endif

endmodule
